multi_road_traffic_controller: RTL

MULTI_ROAD_TRAFFIC_CONTROLLER -- requirements
Module: multi_road_traffic_controller

---
 rtl/multi_road_traffic_controller_pkg.sv | 26 ++
 rtl/multi_road_traffic_controller_if.sv | 32 +++
 rtl/multi_road_traffic_controller_rr.sv | 32 +++
 rtl/multi_road_traffic_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/multi_road_traffic_controller_pkg.sv
// traffic_pkg: shared encodings and default timing for the multi-road
// traffic controller.
// Contents: light encodings, controller state / phase encoding (the
// phase output is the state itself), and default parameter values.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_ALLRED = 2'b10,
        ST_WALK   = 2'b11
    } state_t;

    localparam logic [2:0] LIGHT_GREEN  = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b001;

    localparam int DEF_N_ROADS   = 4;
    localparam int DEF_GREEN_MIN = 10;
    localparam int DEF_GREEN_MAX = 30;
    localparam int DEF_YELLOW_T  = 4;
    localparam int DEF_ALLRED_T  = 2;
    localparam int DEF_CNT_W     = 6;
    localparam int DEF_WALK_T    = 8;

endpackage

// File: rtl/multi_road_traffic_controller_if.sv
// multi_road_traffic_controller_if: road-side signal bundle.
// Signals: detector (per-road vehicle present), lights (3 bits per road),
// active_road, phase; with TRAFFIC_PED_WALK_EN also ped_req and walk.
// Modports: master = intersection side (drives detectors, sees lights),
//           slave  = controller.
interface multi_road_traffic_controller_if
    import traffic_pkg::*;
#(
    parameter int N_ROADS = DEF_N_ROADS
);
    localparam int IDX_W = $clog2(N_ROADS);

    logic [N_ROADS-1:0]   detector;
    logic [3*N_ROADS-1:0] lights;
    logic [IDX_W-1:0]     active_road;
    logic [1:0]           phase;
`ifdef TRAFFIC_PED_WALK_EN
    logic                 ped_req;
    logic                 walk;

    modport master (output detector, output ped_req,
                    input lights, input active_road, input phase, input walk);
    modport slave  (input detector, input ped_req,
                    output lights, output active_road, output phase, output walk);
`else
    modport master (output detector,
                    input lights, input active_road, input phase);
    modport slave  (input detector,
                    output lights, output active_road, output phase);
`endif

endinterface

// File: rtl/multi_road_traffic_controller_rr.sv
// rr_next_road: combinational round-robin pick of the next road to serve.
// Ports: i_pending (request vector), i_cur (current road index),
//        o_next (first pending road above i_cur, wrapping; i_cur if none),
//        o_valid (any road pending).
module rr_next_road #(
    parameter int N_ROADS = 4,
    parameter int IDX_W   = $clog2(N_ROADS)
) (
    input  logic [N_ROADS-1:0] i_pending,
    input  logic [IDX_W-1:0]   i_cur,
    output logic [IDX_W-1:0]   o_next,
    output logic               o_valid
);

    logic [IDX_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest pending road
    // (lowest offset above i_cur) is the last one written.
    always_comb begin
        o_next  = i_cur;
        o_valid = 1'b0;
        w_idx   = i_cur;
        for (int off = N_ROADS; off >= 1; off--) begin
            w_idx = IDX_W'((int'(i_cur) + off) % N_ROADS);
            if (i_pending[w_idx]) begin
                o_next  = w_idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_road_traffic_controller.sv
// multi_road_traffic_controller: round-robin signal controller for
// N_ROADS approaches with minimum/maximum green, yellow and all-red
// clearance.
// Ports: i_clk, i_rst (synchronous, active high), bus (slave modport:
//        detector in; lights, active_road, phase out).
// Optional feature: define TRAFFIC_PED_WALK_EN to add the pedestrian
// WALK phase (bus.ped_req in, bus.walk out, parameter WALK_T).
//
// state  | meaning
// GREEN  | active_road green, others red; rests while nobody else waits
// YELLOW | active_road yellow for YELLOW_T cycles
// ALLRED | all red for ALLRED_T cycles (also the reset state)
// WALK   | all red, pedestrian walk for WALK_T cycles (feature only)
module multi_road_traffic_controller
    import traffic_pkg::*;
#(
    parameter int N_ROADS   = DEF_N_ROADS,
    parameter int GREEN_MIN = DEF_GREEN_MIN,
    parameter int GREEN_MAX = DEF_GREEN_MAX,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T,
    parameter int CNT_W     = DEF_CNT_W
`ifdef TRAFFIC_PED_WALK_EN
    ,
    parameter int WALK_T    = DEF_WALK_T
`endif
) (
    input  logic i_clk,
    input  logic i_rst,
    multi_road_traffic_controller_if.slave bus
);

    localparam int IDX_W = $clog2(N_ROADS);

    // Counter holds cycles already spent in the state, so the last cycle
    // of an N-cycle state is the one where the counter reads N-1.
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] GMAX_SAT  = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);
    localparam logic [N_ROADS-1:0] ONE     = {{(N_ROADS-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [N_ROADS-1:0]   r_pend;
    logic [IDX_W-1:0]     r_active;
    logic [IDX_W-1:0]     r_next;

    logic [IDX_W-1:0]     w_rr_next;
    logic                 w_rr_valid;
    logic [N_ROADS-1:0]   w_active_mask;
    logic [N_ROADS-1:0]   w_green_mask;
    logic [N_ROADS-1:0]   w_entry_mask;
    logic                 w_enter_green;
    logic                 w_other_pend;
    logic                 w_green_done;
    logic [3*N_ROADS-1:0] w_lights;

`ifdef TRAFFIC_PED_WALK_EN
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WALK_T - 1);
    logic r_ped_pend;
    logic r_walk_due;
    logic w_enter_walk;
`endif

    rr_next_road #(
        .N_ROADS (N_ROADS),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_pending (r_pend),
        .i_cur     (r_active),
        .o_next    (w_rr_next),
        .o_valid   (w_rr_valid)
    );

    assign w_active_mask = ONE << r_active;
    assign w_green_mask  = (r_state == ST_GREEN) ? w_active_mask : '0;
    assign w_enter_green = (r_state != ST_GREEN) && (w_state_nxt == ST_GREEN);
    assign w_entry_mask  = w_enter_green ? (ONE << r_next) : '0;

`ifdef TRAFFIC_PED_WALK_EN
    assign w_other_pend = (|(r_pend & ~w_active_mask)) || r_ped_pend;
    assign w_enter_walk = (r_state != ST_WALK) && (w_state_nxt == ST_WALK);
`else
    assign w_other_pend = |(r_pend & ~w_active_mask);
`endif

    // Past GREEN_MIN a waiting request ends green unless our own detector
    // is still high; GREEN_MAX caps the extension.
    assign w_green_done = w_other_pend && (r_cnt >= GMIN_LAST) &&
                          (!bus.detector[r_active] || (r_cnt >= GMAX_LAST));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_GREEN:  if (w_green_done)     w_state_nxt = ST_YELLOW;
            ST_YELLOW: if (r_cnt == Y_LAST)  w_state_nxt = ST_ALLRED;
            ST_ALLRED: begin
                if (r_cnt == AR_LAST) begin
`ifdef TRAFFIC_PED_WALK_EN
                    w_state_nxt = r_walk_due ? ST_WALK : ST_GREEN;
`else
                    w_state_nxt = ST_GREEN;
`endif
                end
            end
`ifdef TRAFFIC_PED_WALK_EN
            ST_WALK:   if (r_cnt == W_LAST)  w_state_nxt = ST_ALLRED;
`endif
            default:   w_state_nxt = ST_ALLRED;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_ALLRED;
            r_cnt    <= '0;
            r_pend   <= '0;
            r_active <= '0;
            r_next   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (!((r_state == ST_GREEN) && (r_cnt == GMAX_SAT))) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Entry clear wins over a same-cycle detector on the granted road.
            r_pend <= (r_pend | (bus.detector & ~w_green_mask)) & ~w_entry_mask;
            if ((r_state == ST_GREEN) && (w_state_nxt == ST_YELLOW)) begin
                r_next <= w_rr_valid ? w_rr_next : r_active;
            end
            if (w_enter_green) begin
                r_active <= r_next;
            end
        end
    end

`ifdef TRAFFIC_PED_WALK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ped_pend <= 1'b0;
            r_walk_due <= 1'b0;
        end else begin
            r_ped_pend <= (r_ped_pend || (bus.ped_req && (r_state != ST_WALK)))
                          && !w_enter_walk;
            // Decide at green exit whether the coming clearance leads to WALK;
            // later ped requests wait for the next round.
            if ((r_state == ST_GREEN) && (w_state_nxt == ST_YELLOW)) begin
                r_walk_due <= r_ped_pend;
            end else if (w_enter_walk) begin
                r_walk_due <= 1'b0;
            end
        end
    end

    assign bus.walk = (r_state == ST_WALK);
`endif

    always_comb begin
        w_lights = {N_ROADS{LIGHT_RED}};
        for (int i = 0; i < N_ROADS; i++) begin
            if (IDX_W'(i) == r_active) begin
                if (r_state == ST_GREEN) begin
                    w_lights[3*i +: 3] = LIGHT_GREEN;
                end else if (r_state == ST_YELLOW) begin
                    w_lights[3*i +: 3] = LIGHT_YELLOW;
                end
            end
        end
    end

    assign bus.lights      = w_lights;
    assign bus.active_road = r_active;
    assign bus.phase       = r_state;

endmodule
